// File: rtl/sum_sq.sv
// Iterative sum-of-squares unit: out = a*a + b*b, saturating to all-ones on overflow.
// One shift-add step per cycle; A is squared first, then B, into a shared accumulator.
module sum_sq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               go,
    input  logic [WIDTH/2-1:0] a,
    input  logic [WIDTH/2-1:0] b,
    output logic [WIDTH-1:0]   out,
    output logic               overflow,
    output logic               done
);

    localparam int HALF = WIDTH / 2;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQ_A = 2'd1,
        ST_SQ_B = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH:0]    r_mcand;
    logic [HALF-1:0]   r_mult;
    logic [HALF-1:0]   r_opb;
    logic [WIDTH:0]    r_acc;
    logic [IW-1:0]     r_idx;
    logic [WIDTH-1:0]  r_out;
    logic              r_ovf;
    logic              r_done;

    logic              w_last;
    logic              w_start;
    logic [WIDTH:0]    w_sum;

    // Next-state and step datapath; the DONE edge may launch the next op so
    // a held go gives one result every 2*HALF+1 cycles.
    always_comb begin
        w_next  = r_state;
        w_last  = (r_idx == LAST_IDX);
        w_start = 1'b0;
        if (r_mult[0]) begin
            w_sum = r_acc + r_mcand;
        end else begin
            w_sum = r_acc;
        end
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_next  = ST_SQ_A;
                    w_start = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SQ_A: begin
                if (w_last) begin
                    w_next = ST_SQ_B;
                end else begin
                    w_next = ST_SQ_A;
                end
            end
            ST_SQ_B: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_SQ_B;
                end
            end
            ST_DONE: begin
                if (go) begin
                    w_next  = ST_SQ_A;
                    w_start = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand, accumulator and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand <= '0;
            r_mult  <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_mcand <= {{(WIDTH + 1 - HALF){1'b0}}, a};
                r_mult  <= a;
                r_opb   <= b;
                r_acc   <= '0;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    ST_SQ_A: begin
                        r_acc <= w_sum;
                        if (w_last) begin
                            r_mcand <= {{(WIDTH + 1 - HALF){1'b0}}, r_opb};
                            r_mult  <= r_opb;
                            r_idx   <= '0;
                        end else begin
                            r_mcand <= r_mcand << 1;
                            r_mult  <= r_mult >> 1;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                    ST_SQ_B: begin
                        r_acc   <= w_sum;
                        r_mcand <= r_mcand << 1;
                        r_mult  <= r_mult >> 1;
                        if (w_last) begin
                            r_idx  <= '0;
                            r_done <= 1'b1;
                            r_ovf  <= w_sum[WIDTH];
                            if (w_sum[WIDTH]) begin
                                r_out <= '1;
                            end else begin
                                r_out <= w_sum[WIDTH-1:0];
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    default: begin
                        r_acc <= r_acc;
                    end
                endcase
            end
        end
    end

    assign out      = r_out;
    assign overflow = r_ovf;
    assign done     = r_done;

endmodule

// File: tb/tb_sum_sq.sv
// Directed bench for sum_sq at WIDTH=8 plus a model-checked sweep at WIDTH=32.
module tb_sum_sq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go8 = 1'b0;
    logic [3:0]  a8 = 4'd0;
    logic [3:0]  b8 = 4'd0;
    logic [7:0]  out8;
    logic        ovf8;
    logic        done8;
    logic        go32 = 1'b0;
    logic [15:0] a32 = 16'd0;
    logic [15:0] b32 = 16'd0;
    logic [31:0] out32;
    logic        ovf32;
    logic        done32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sum_sq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .go(go8), .a(a8), .b(b8),
        .out(out8), .overflow(ovf8), .done(done8)
    );

    sum_sq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .go(go32), .a(a32), .b(b32),
        .out(out32), .overflow(ovf32), .done(done32)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Counts edges until done is seen (sampled 1 time unit after each edge); -1 on timeout.
    task automatic wait_done(input bit w32, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if ((w32 ? done32 : done8) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_done8(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1) cnt++;
        end
    endtask

    // Launch on the next edge (T0), run to done and check result, latency and pulse width.
    task automatic op8(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input logic [7:0] eout, input logic eovf);
        int n;
        go8 = 1'b1; a8 = av; b8 = bv;
        @(posedge clk);
        #1;
        go8 = 1'b0; a8 = 4'd0; b8 = 4'd0;
        wait_done(1'b0, 40, n);
        check({tag, "_lat"}, n, 8);
        check({tag, "_out"}, out8, eout);
        check({tag, "_ovf"}, ovf8, eovf);
        @(posedge clk);
        #1;
        check({tag, "_done_low"}, done8, 1'b0);
    endtask

    initial begin
        int n;
        int cnt;
        logic [63:0] s;
        logic [31:0] eo;
        logic        ev;

        #3;
        check("rst_out8", out8, 8'd0);
        check("rst_ovf8", ovf8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_out32", out32, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        op8("t3_4", 4'd3, 4'd4, 8'd25, 1'b0);
        op8("t15_15", 4'd15, 4'd15, 8'd255, 1'b1);
        op8("t15_0", 4'd15, 4'd0, 8'd225, 1'b0);

        // go pulsed with new operands during an operation must be ignored
        go8 = 1'b1; a8 = 4'd0; b8 = 4'd0;
        @(posedge clk);
        #1;
        go8 = 1'b0;
        @(posedge clk);
        #1;
        go8 = 1'b1; a8 = 4'd9; b8 = 4'd9;
        repeat (4) @(posedge clk);
        #1;
        go8 = 1'b0;
        wait_done(1'b0, 40, n);
        check("ign_lat", n, 3);
        check("ign_out", out8, 8'd0);
        check("ign_ovf", ovf8, 1'b0);
        count_done8(20, cnt);
        check("ign_one_done", cnt, 0);

        // go held high: back-to-back ops, done pulses 9 cycles apart
        go8 = 1'b1; a8 = 4'd1; b8 = 4'd2;
        @(posedge clk);
        #1;
        a8 = 4'd2; b8 = 4'd3;
        wait_done(1'b0, 40, n);
        check("b2b_lat1", n, 8);
        check("b2b_out1", out8, 8'd5);
        wait_done(1'b0, 40, n);
        go8 = 1'b0;
        check("b2b_gap", n, 9);
        check("b2b_out2", out8, 8'd13);
        @(posedge clk);
        #1;
        check("b2b_done_low", done8, 1'b0);
        count_done8(12, cnt);
        check("b2b_no_third", cnt, 0);

        // asynchronous reset mid-operation
        go8 = 1'b1; a8 = 4'd7; b8 = 4'd7;
        @(posedge clk);
        #1;
        go8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_out", out8, 8'd0);
        check("arst_ovf", ovf8, 1'b0);
        check("arst_done", done8, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        count_done8(20, cnt);
        check("arst_no_done", cnt, 0);
        op8("t2_2", 4'd2, 4'd2, 8'd8, 1'b0);

        // WIDTH=32 sweep against a*a+b*b with saturation
        for (int k = 0; k < 1000; k++) begin
            if (k == 0) begin
                a32 = 16'hFFFF; b32 = 16'hFFFF;
            end else if (k == 1) begin
                a32 = 16'd0; b32 = 16'd0;
            end else if (k == 2) begin
                a32 = 16'hFFFF; b32 = 16'd0;
            end else begin
                a32 = 16'($urandom_range(0, 65535));
                b32 = 16'($urandom_range(0, 65535));
            end
            s  = 64'(a32) * 64'(a32) + 64'(b32) * 64'(b32);
            ev = (s > 64'h0000_0000_FFFF_FFFF);
            eo = ev ? 32'hFFFF_FFFF : s[31:0];
            go32 = 1'b1;
            @(posedge clk);
            #1;
            go32 = 1'b0; a32 = ~a32; b32 = ~b32;
            wait_done(1'b1, 60, n);
            check("w32_lat", n, 32);
            check("w32_out", out32, eo);
            check("w32_ovf", ovf32, ev);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
